memory_stage: RTL
=================

Name: memory_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline: sits between the EX/MEM register and the MEM/WB register (Memory2Writeback_d).
- Drives a variable-latency data-memory bus using a req/ack handshake.
- Performs byte, half and word lane steering with sign or zero extension.
- Stalls the pipeline while an access is outstanding and times out hung accesses.

Parameters:
- TIMEOUT_CYC, 255: BUSY cycles without ack before the access is aborted. Range 1..255.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- MemReadM  in  1  load in MEM
- MemWriteM  in  1  store in MEM
- MemSizeM  in  2  00 byte, 01 half, 10 word; 11 treated as word
- MemSignedM  in  1  sign-extend sub-word loads
- RegWriteM  in  1  instruction writes the register file
- ALUOutM  in  32  effective address / ALU result
- WriteDataM  in  32  store data (low bits valid)
- WriteRegM  in  5  destination register
- ReadDataM  out  32  extended load data to MEM/WB
- RegWriteOutM  out  1  gated register write to MEM/WB
- StallM  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- BusErrM  out  1  one-cycle pulse on timeout
- MisalignM  out  1  one-cycle pulse on misaligned access (see optional feature)
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  write enable, registered
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00}), registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_be  out  4  byte enables, registered
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  single-cycle completion

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset mid-access: forces IDLE next edge; a later stray ack is ignored in IDLE.
- acc = MemReadM | MemWriteM. If both are set, the access is a store.
- State IDLE:
  - StallM = acc.
  - On acc: register req=1, we, addr, wdata, be; counter=0; go BUSY.
  - No acc: stay IDLE.
- State BUSY:
  - StallM=1. Request fields held stable. Counter increments each cycle.
  - ack may arrive in the first BUSY cycle.
  - On ack: req<=0; load data captured into ReadDataM; go DONE.
  - Else, when counter==TIMEOUT_CYC-1: req<=0; ReadDataM<=0; BusErrM pulses in DONE; go DONE.
  - ack and timeout in the same cycle: ack wins, no error.
- State DONE:
  - StallM=0, so the pipeline advances at the end of this cycle. Go IDLE.
- ReadDataM and register write:
  - ReadDataM holds its last value except at load capture and timeout.
  - RegWriteOutM = RegWriteM & ~StallM & ~BusErrM.
  - Non-memory instructions pass through with zero added latency.
- Minimum memory access: 3 cycles (IDLE, BUSY, DONE), i.e. 2 stall cycles. Back-to-back memory instructions repeat the sequence.
- Lanes (little-endian, a = ALUOutM[1:0]):
  - Byte: be = 1<<a; wdata = {4{WriteDataM[7:0]}}.
  - Half: be = a[1] ? 1100 : 0011; wdata = {2{WriteDataM[15:0]}}.
  - Word: be = 1111.
- Load extract: rdata >> (8*a), then zero-extend or sign-extend from bit 7 (byte) or bit 15 (half).
- Misalignment (half with a[0]=1, word with a!=0): address low bits ignored, aligned access performed, MisalignM=0.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access in IDLE issues no bus request and goes straight to DONE. In that cycle MisalignM=1, RegWriteOutM=0 and ReadDataM is unchanged. StallM=1 only in the IDLE cycle.
- Undefined: alignment is forced as above and MisalignM is tied to 0.

Decomposition:
- Package mem_pkg holds:
  - state enum IDLE/BUSY/DONE;
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - a function computing be from size and a.
- One natural sub-module, load_align: purely combinational rdata/size/signed/a -> ReadData extension, reusable by the writeback path.

Test Plan:
- LW at 0x100, ack in first BUSY cycle, rdata=0xDEADBEEF -> StallM high 2 cycles; ReadDataM=0xDEADBEEF; RegWriteOutM=1 in DONE.
- LB signed at 0x103, rdata=0x80FF1122 -> ReadDataM=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x102, WriteDataM=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x100.
- TIMEOUT_CYC=4, ack never returned -> req high exactly 4 BUSY cycles; BusErrM pulses once; ReadDataM=0; RegWriteOutM=0.
- reset asserted in the 2nd BUSY cycle, then ack arrives -> req=0 after the edge, state IDLE, ack ignored, StallM=0.
- With MEM_MISALIGN_TRAP_EN: LW at 0x101 -> no dmem_req, MisalignM=1 for one cycle, RegWriteOutM=0. Without the macro: access issued to 0x100.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM stage: FSM states, size codes,
// bus payload/context structs and lane-steering helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    // Request fields presented on the data-memory bus
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dmem_req_t;

    // Load attributes latched when the access is issued
    typedef struct packed {
        logic       is_load;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] a;
    } mem_ctx_t;

    // Byte enables from access size and address low bits (little-endian)
    function automatic logic [BE_W-1:0] calc_be(input logic [1:0] size, input logic [1:0] a);
        logic [BE_W-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across all lanes the access could target
    function automatic logic [XLEN-1:0] calc_wdata(input logic [1:0] size, input logic [XLEN-1:0] data);
        logic [XLEN-1:0] wd;
        case (size)
            SZ_BYTE: wd = {4{data[7:0]}};
            SZ_HALF: wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Half on an odd byte, or word/11 off a word boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: shifts the addressed lane down and sign/zero extends.
// Misaligned halves/words use the aligned lane (address low bits dropped).
module load_align
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_size,
    input  logic            i_signed,
    input  logic [1:0]      i_a,
    output logic [XLEN-1:0] o_data_c
);

    logic [1:0]      w_off;
    logic [XLEN-1:0] w_shifted;

    // Effective byte offset after forcing natural alignment
    always_comb begin
        w_off = 2'b00;
        case (i_size)
            SZ_BYTE: w_off = i_a;
            SZ_HALF: w_off = {i_a[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    assign w_shifted = i_rdata >> {w_off, 3'b000};

    // Extend the selected lane to full width
    always_comb begin
        o_data_c = w_shifted;
        case (i_size)
            SZ_BYTE: o_data_c = {{24{i_signed & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: o_data_c = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data_c = w_shifted;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: issues req/ack data-memory accesses, steers lanes,
// stalls the pipeline while busy and aborts hung accesses after TIMEOUT_CYC.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned accesses are not issued
// and raise a one-cycle MisalignM instead.
module memory_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [1:0]       MemSizeM,
    input  logic             MemSignedM,
    input  logic             RegWriteM,
    input  logic [XLEN-1:0]  ALUOutM,
    input  logic [XLEN-1:0]  WriteDataM,
    input  logic [4:0]       WriteRegM,
    output logic [XLEN-1:0]  ReadDataM,
    output logic             RegWriteOutM,
    output logic             StallM,
    output logic             BusErrM,
    output logic             MisalignM,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [XLEN-1:0]  dmem_addr,
    output logic [XLEN-1:0]  dmem_wdata,
    output logic [BE_W-1:0]  dmem_be,
    input  logic [XLEN-1:0]  dmem_rdata,
    input  logic             dmem_ack
);

    mem_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic            r_req, w_req_nxt;
    dmem_req_t       r_bus, w_bus_nxt;
    mem_ctx_t        r_ctx, w_ctx_nxt;
    logic [XLEN-1:0] r_rdata, w_rdata_nxt;
    logic            r_bus_err, w_bus_err_nxt;
    logic            r_misalign, w_misalign_nxt;

    logic            w_acc;
    logic            w_trap;
    logic            w_timeout;
    logic [XLEN-1:0] w_load_data;
    logic            w_unused;

    assign w_acc     = MemReadM | MemWriteM;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_unused  = ^WriteRegM;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_acc & is_misaligned(MemSizeM, ALUOutM[1:0]);
`else
    assign w_trap = 1'b0;
`endif

    load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_size   (r_ctx.size),
        .i_signed (r_ctx.sgn),
        .i_a      (r_ctx.a),
        .o_data_c (w_load_data)
    );

    // Next-state and next-register values for the access sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_req_nxt      = r_req;
        w_bus_nxt      = r_bus;
        w_ctx_nxt      = r_ctx;
        w_rdata_nxt    = r_rdata;
        w_bus_err_nxt  = 1'b0;
        w_misalign_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_trap) begin
                    w_misalign_nxt = 1'b1;
                    w_state_nxt    = DONE;
                end else if (w_acc) begin
                    w_req_nxt       = 1'b1;
                    w_bus_nxt.we    = MemWriteM;
                    w_bus_nxt.addr  = {ALUOutM[XLEN-1:2], 2'b00};
                    w_bus_nxt.wdata = calc_wdata(MemSizeM, WriteDataM);
                    w_bus_nxt.be    = calc_be(MemSizeM, ALUOutM[1:0]);
                    w_ctx_nxt.is_load = MemReadM & ~MemWriteM;
                    w_ctx_nxt.size    = MemSizeM;
                    w_ctx_nxt.sgn     = MemSignedM;
                    w_ctx_nxt.a       = ALUOutM[1:0];
                    w_cnt_nxt       = '0;
                    w_state_nxt     = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    w_req_nxt   = 1'b0;
                    if (r_ctx.is_load) begin
                        w_rdata_nxt = w_load_data;
                    end
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_req_nxt     = 1'b0;
                    w_rdata_nxt   = '0;
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_bus      <= '0;
            r_ctx      <= '0;
            r_rdata    <= '0;
            r_bus_err  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_req      <= w_req_nxt;
            r_bus      <= w_bus_nxt;
            r_ctx      <= w_ctx_nxt;
            r_rdata    <= w_rdata_nxt;
            r_bus_err  <= w_bus_err_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign StallM       = ((r_state == IDLE) & w_acc) | (r_state == BUSY);
    assign RegWriteOutM = RegWriteM & ~StallM & ~BusErrM & ~MisalignM;
    assign ReadDataM    = r_rdata;
    assign BusErrM      = r_bus_err;
    assign MisalignM    = r_misalign;
    assign dmem_req     = r_req;
    assign dmem_we      = r_bus.we;
    assign dmem_addr    = r_bus.addr;
    assign dmem_wdata   = r_bus.wdata;
    assign dmem_be      = r_bus.be;

endmodule
